st_merge: RTL and testbench
===========================

ST_MERGE -- requirements
Module: st_merge

Interface
REQ-001 Parameter BYTE_W, default 6, bits per byte.
REQ-002 Parameter NBYTES, default 5, bytes per word (1..7).
REQ-003 Parameter ADDR_W, default 12, memory address width.
REQ-004 Derived W = 1 + NBYTES*BYTE_W; bit W-1 is the sign, byte 1 is the most significant, byte NBYTES is the least significant.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  request strobe, sampled only when busy=0.
REQ-008 addr_in  in  ADDR_W  target address.
REQ-009 value_in  in  W  register value to store.
REQ-010 field  in  6  field code F=8L+R.
REQ-011 busy  out  1  operation in progress.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 err  out  1  invalid field, valid only while done=1.
REQ-014 mem_addr  out  ADDR_W  latched target address.
REQ-015 mem_rd  out  1  read request, held until mem_rvalid.
REQ-016 mem_rvalid  in  1  read data valid.
REQ-017 mem_rdata  in  W  old memory word.
REQ-018 mem_we  out  1  write request, held until mem_wack.
REQ-019 mem_wack  in  1  write accepted.
REQ-020 mem_wdata  out  W  merged word, stable while mem_we=1.

Function
REQ-021 States: IDLE, READ, WRITE.
REQ-022 On start in IDLE, the block latches value_in, field and addr_in.
- Valid field (L<=R<=NBYTES): next state READ, busy=1.
- Invalid field: stay IDLE; next cycle done=1, err=1; no mem_rd, no mem_we.
REQ-023 READ drives mem_rd=1.
- On the edge sampling mem_rvalid=1: the merged word is registered into mem_wdata; next state WRITE.
REQ-024 WRITE drives mem_we=1.
- On the edge sampling mem_wack=1: next state IDLE, done=1 and busy=0 for the following cycle.
REQ-025 Merge rule:
- If L=0, the sign comes from value_in, otherwise from mem_rdata.
- With L'=max(L,1), memory bytes L'..R receive the rightmost R-L'+1 bytes of value_in.
- All other bits come from mem_rdata.
REQ-026 Field (0:0) replaces the sign only; field (0:NBYTES) replaces the whole word.
REQ-027 start while busy=1 is ignored; latched operands do not change mid-operation.
REQ-028 Minimum latency with valid field and zero-wait memory: start sampled at edge 0, mem_rvalid at edge 1, mem_wack at edge 2, done high during cycle 3.
REQ-029 A new start is accepted in the cycle where done=1.
REQ-030 Wait states on mem_rvalid or mem_wack are unbounded; mem_addr is held constant throughout.

Reset
REQ-031 rst_n=0 asynchronously forces state IDLE, busy=0, done=0, err=0, mem_rd=0, mem_we=0, mem_addr=0, mem_wdata=0, latched operands=0.
REQ-032 Reset during READ or WRITE aborts the operation; no done pulse follows and no write completes.

Configuration
REQ-033 Macro ST_MERGE_FULLWORD_BYPASS_EN controls the full-word bypass.
- Defined: field (0:NBYTES) skips READ, loads mem_wdata=value_in and enters WRITE directly; done arrives one cycle earlier than REQ-028.
- Undefined: every valid field passes through READ.

Verification
REQ-034 Defaults, mem word = sign 1, bytes 1,2,3,4,5; value_in = sign 0, bytes 6,7,8,9,10; F=11 (1:3) -> mem_wdata = sign 1, bytes 8,9,10,4,5; done at cycle 3.
REQ-035 Same data, F=0 (0:0) -> mem_wdata = sign 0, bytes 1,2,3,4,5.
REQ-036 F=34 (4:2) -> done=1, err=1 one cycle after start; mem_rd and mem_we never assert.
REQ-037 F=5 (0:5) with macro defined -> no mem_rd; mem_wdata = value_in.
- Without the macro: mem_rd asserts and the same mem_wdata results.
REQ-038 mem_rvalid delayed 3 cycles, then rst_n pulsed low in WRITE -> outputs return to reset values immediately; no done pulse.
REQ-039 start pulsed again while busy with a different addr_in -> ignored; mem_addr unchanged; exactly one done pulse.

Source files
------------

// File: rtl/st_merge.sv
// st_merge: read-modify-write of a byte field F=8L+R into one memory word (IDLE -> READ -> WRITE).
// Optional macro ST_MERGE_FULLWORD_BYPASS_EN: field (0:NBYTES) skips READ and writes value_in directly.
module st_merge #(
   parameter int BYTE_W = 6,
   parameter int NBYTES = 5,
   parameter int ADDR_W = 12,
   localparam int W = 1 + NBYTES*BYTE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [W-1:0]      value_in,
   input  logic [5:0]        field,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic              mem_rvalid,
   input  logic [W-1:0]      mem_rdata,
   output logic              mem_we,
   input  logic              mem_wack,
   output logic [W-1:0]      mem_wdata
);
   localparam int         DW  = NBYTES*BYTE_W;
   localparam logic [2:0] NB3 = 3'(NBYTES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [W-1:0]      r_val;
   logic [5:0]        r_field;
   logic [ADDR_W-1:0] r_addr;
   logic [W-1:0]      r_wdata;
   logic              r_done;
   logic              r_err;

   logic              w_valid;
   logic              w_bypass;
   logic              w_accept;
   logic              w_ld_merge;
   logic              w_ld_bypass;
   logic              w_done_nxt;
   logic              w_err_nxt;
   logic [2:0]        w_l;
   logic [2:0]        w_r;
   logic [2:0]        w_lp;
   logic [DW-1:0]     w_shift;
   logic [DW-1:0]     w_mask;
   logic [W-1:0]      w_merged;

   // Field check uses the live input since it decides the transition out of IDLE.
   assign w_valid = (field[5:3] <= field[2:0]) && (field[2:0] <= NB3);

`ifdef ST_MERGE_FULLWORD_BYPASS_EN
   assign w_bypass = (field == {3'd0, NB3});
`else
   assign w_bypass = 1'b0;
`endif

   assign w_l  = r_field[5:3];
   assign w_r  = r_field[2:0];
   assign w_lp = (w_l == 3'd0) ? 3'd1 : w_l;

   // Right-aligned value bytes moved up so that value byte NBYTES lands on memory byte R.
   assign w_shift = r_val[DW-1:0] << (BYTE_W * (NBYTES - int'(w_r)));

   always_comb begin
      w_mask = '0;
      for (int k = 1; k <= NBYTES; k++) begin
         if ((3'(k) >= w_lp) && (3'(k) <= w_r)) begin
            w_mask[(NBYTES-k)*BYTE_W +: BYTE_W] = {BYTE_W{1'b1}};
         end
      end
   end

   assign w_merged = {(w_l == 3'd0) ? r_val[W-1] : mem_rdata[W-1],
                      (mem_rdata[DW-1:0] & ~w_mask) | (w_shift & w_mask)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_ld_merge  = 1'b0;
      w_ld_bypass = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      mem_rd      = 1'b0;
      mem_we      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               if (!w_valid) begin
                  w_done_nxt = 1'b1;
                  w_err_nxt  = 1'b1;
               end else if (w_bypass) begin
                  w_ld_bypass = 1'b1;
                  w_next      = S_WRITE;
               end else begin
                  w_next = S_READ;
               end
            end
         end
         S_READ: begin
            mem_rd = 1'b1;
            if (mem_rvalid) begin
               w_ld_merge = 1'b1;
               w_next     = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_we = 1'b1;
            if (mem_wack) begin
               w_done_nxt = 1'b1;
               w_next     = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_val   <= '0;
         r_field <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_val   <= value_in;
            r_field <= field;
            r_addr  <= addr_in;
         end
         if (w_ld_merge) begin
            r_wdata <= w_merged;
         end else if (w_ld_bypass) begin
            r_wdata <= value_in;
         end
         r_done <= w_done_nxt;
         r_err  <= w_err_nxt;
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign err       = r_err;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_st_merge.sv
// Directed bench for st_merge: memory responder with programmable wait states, per-scenario tasks.
module tb_st_merge;
   localparam int BYTE_W = 6;
   localparam int NBYTES = 5;
   localparam int ADDR_W = 12;
   localparam int W      = 1 + NBYTES*BYTE_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] addr_in = '0;
   logic [W-1:0]      value_in = '0;
   logic [5:0]        field = '0;
   logic              busy, done, err, mem_rd, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [W-1:0]      mem_wdata;
   logic              mem_rvalid = 1'b0;
   logic              mem_wack = 1'b0;
   logic [W-1:0]      mem_rdata = '0;

   int checks = 0;
   int failures = 0;
   int rd_delay = 0;
   int wr_delay = 0;
   int rd_cnt = 0, wr_cnt = 0;
   int rd_cycles = 0, we_cycles = 0, done_cnt = 0, writes = 0;
   logic [W-1:0]      last_wdata = '0;
   logic [ADDR_W-1:0] last_waddr = '0;

   always #5 clk = ~clk;

   st_merge #(.BYTE_W(BYTE_W), .NBYTES(NBYTES), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .addr_in(addr_in), .value_in(value_in),
      .field(field), .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_we(mem_we), .mem_wack(mem_wack), .mem_wdata(mem_wdata)
   );

   function automatic logic [W-1:0] mkw(input logic s, input int b1, input int b2,
                                        input int b3, input int b4, input int b5);
      return {s, 6'(b1), 6'(b2), 6'(b3), 6'(b4), 6'(b5)};
   endfunction

   // Memory responder: reacts on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      mem_rvalid = 1'b0;
      mem_wack   = 1'b0;
      if (mem_rd) begin
         rd_cycles++;
         if (rd_cnt >= rd_delay) mem_rvalid = 1'b1;
         rd_cnt++;
      end else begin
         rd_cnt = 0;
      end
      if (mem_we) begin
         we_cycles++;
         if (wr_cnt >= wr_delay) begin
            mem_wack   = 1'b1;
            writes++;
            last_wdata = mem_wdata;
            last_waddr = mem_addr;
         end
         wr_cnt++;
      end else begin
         wr_cnt = 0;
      end
      if (done) done_cnt++;
   end

   // Issues one request; lat = cycle index (edge 0 = start sample) in which done is seen, -1 on timeout.
   task automatic do_op(input logic [ADDR_W-1:0] a, input logic [W-1:0] v, input logic [5:0] f,
                        input bit immediate, output int lat);
      if (!immediate) begin
         @(negedge clk); #1;
      end
      addr_in = a; value_in = v; field = f; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (mem_rd !== 1'b0 || mem_we !== 1'b0) begin
         failures++; $display("FAIL reset_rdwe got=%b%b exp=00", mem_rd, mem_we); end
      checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
      @(negedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_merge_basic();
      int lat, rd0, we0;
      rd0 = rd_cycles; we0 = we_cycles;
      do_op(12'h123, mkw(0,6,7,8,9,10), 6'd11, 1'b0, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
      checks++; if (last_wdata !== mkw(1,8,9,10,4,5)) begin
         failures++; $display("FAIL basic_wdata got=%h exp=%h", last_wdata, mkw(1,8,9,10,4,5)); end
      checks++; if (last_waddr !== 12'h123) begin
         failures++; $display("FAIL basic_waddr got=%h exp=123", last_waddr); end
      checks++; if ((rd_cycles - rd0) !== 1 || (we_cycles - we0) !== 1) begin
         failures++; $display("FAIL basic_handshake got=rd%0d/we%0d exp=rd1/we1", rd_cycles-rd0, we_cycles-we0); end
   endtask

   task automatic test_patterns();
      logic [5:0]   fld [4];
      logic [W-1:0] exp [4];
      int lat;
      fld[0] = 6'd0;  exp[0] = mkw(0,1,2,3,4,5);
      fld[1] = 6'd45; exp[1] = mkw(1,1,2,3,4,10);
      fld[2] = 6'd20; exp[2] = mkw(1,1,8,9,10,5);
      fld[3] = 6'd2;  exp[3] = mkw(0,9,10,3,4,5);
      for (int i = 0; i < 4; i++) begin
         do_op(12'(16 + i), mkw(0,6,7,8,9,10), fld[i], 1'b0, lat);
         checks++; if (lat !== 3 || last_wdata !== exp[i]) begin
            failures++;
            $display("FAIL pattern_f%0d got=lat%0d/%h exp=lat3/%h", fld[i], lat, last_wdata, exp[i]);
         end
      end
   endtask

   task automatic test_invalid();
      logic [5:0] fld [2];
      int lat, rd0, we0;
      fld[0] = 6'd34;
      fld[1] = 6'd6;
      for (int i = 0; i < 2; i++) begin
         rd0 = rd_cycles; we0 = we_cycles;
         do_op(12'h3A0, mkw(0,6,7,8,9,10), fld[i], 1'b0, lat);
         checks++; if (lat !== 1 || err !== 1'b1) begin
            failures++; $display("FAIL invalid_f%0d got=lat%0d/err%b exp=lat1/err1", fld[i], lat, err); end
         checks++; if ((rd_cycles - rd0) !== 0 || (we_cycles - we0) !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL invalid_nomem_f%0d got=rd%0d/we%0d/busy%b exp=rd0/we0/busy0",
                                 fld[i], rd_cycles-rd0, we_cycles-we0, busy); end
      end
      @(negedge clk); #1;
      checks++; if (done !== 1'b0 || err !== 1'b0) begin
         failures++; $display("FAIL invalid_pulse_width got=done%b/err%b exp=00", done, err); end
   endtask

   task automatic test_fullword();
      int lat, rd0;
      rd0 = rd_cycles;
      do_op(12'h055, mkw(0,6,7,8,9,10), 6'd5, 1'b0, lat);
      checks++; if (last_wdata !== mkw(0,6,7,8,9,10)) begin
         failures++; $display("FAIL fullword_wdata got=%h exp=%h", last_wdata, mkw(0,6,7,8,9,10)); end
`ifdef ST_MERGE_FULLWORD_BYPASS_EN
      checks++; if (lat !== 2 || (rd_cycles - rd0) !== 0) begin
         failures++; $display("FAIL fullword_bypass got=lat%0d/rd%0d exp=lat2/rd0", lat, rd_cycles-rd0); end
`else
      checks++; if (lat !== 3 || (rd_cycles - rd0) !== 1) begin
         failures++; $display("FAIL fullword_read got=lat%0d/rd%0d exp=lat3/rd1", lat, rd_cycles-rd0); end
`endif
   endtask

   task automatic test_reset_in_write();
      int rd0, d0, w0;
      bit addr_bad;
      rd_delay = 3; wr_delay = 100; addr_bad = 1'b0;
      rd0 = rd_cycles; d0 = done_cnt; w0 = writes;
      @(negedge clk); #1;
      addr_in = 12'h2B7; value_in = mkw(0,6,7,8,9,10); field = 6'd11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk); #1;
         if (mem_addr !== 12'h2B7) addr_bad = 1'b1;
         if (mem_we) break;
      end
      checks++; if (mem_we !== 1'b1 || (rd_cycles - rd0) !== 4) begin
         failures++; $display("FAIL wait_read got=we%b/rd%0d exp=we1/rd4", mem_we, rd_cycles-rd0); end
      checks++; if (addr_bad !== 1'b0) begin failures++; $display("FAIL wait_addr_hold got=1 exp=0"); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || mem_we !== 1'b0 || mem_rd !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL abort_ctrl got=busy%b/we%b/rd%b/done%b exp=0000", busy, mem_we, mem_rd, done); end
      checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin
         failures++; $display("FAIL abort_data got=%h/%h exp=0/0", mem_addr, mem_wdata); end
      @(negedge clk); #1 rst_n = 1'b1;
      rd_delay = 0; wr_delay = 0;
      repeat (5) @(negedge clk);
      #1;
      checks++; if ((done_cnt - d0) !== 0 || (writes - w0) !== 0 || busy !== 1'b0) begin
         failures++; $display("FAIL abort_nodone got=done%0d/writes%0d/busy%b exp=0/0/0",
                              done_cnt-d0, writes-w0, busy); end
   endtask

   task automatic test_busy_ignore();
      int d0;
      bit addr_bad, seen;
      rd_delay = 2; wr_delay = 2; addr_bad = 1'b0; seen = 1'b0;
      d0 = done_cnt;
      @(negedge clk); #1;
      addr_in = 12'h111; value_in = mkw(0,6,7,8,9,10); field = 6'd11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%b exp=1", busy); end
      addr_in = 12'h222; value_in = mkw(1,63,63,63,63,63); field = 6'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         if (busy && mem_addr !== 12'h111) addr_bad = 1'b1;
         if (done) begin seen = 1'b1; break; end
      end
      repeat (6) @(negedge clk);
      #1;
      checks++; if (seen !== 1'b1 || (done_cnt - d0) !== 1) begin
         failures++; $display("FAIL ignore_one_done got=%0d exp=1", done_cnt-d0); end
      checks++; if (addr_bad !== 1'b0 || last_waddr !== 12'h111) begin
         failures++; $display("FAIL ignore_addr got=%h exp=111", last_waddr); end
      checks++; if (last_wdata !== mkw(1,8,9,10,4,5)) begin
         failures++; $display("FAIL ignore_wdata got=%h exp=%h", last_wdata, mkw(1,8,9,10,4,5)); end
      rd_delay = 0; wr_delay = 0;
   endtask

   task automatic test_back_to_back();
      int lat1, lat2;
      do_op(12'h0A1, mkw(0,6,7,8,9,10), 6'd11, 1'b0, lat1);
      do_op(12'h0A2, mkw(0,6,7,8,9,10), 6'd20, 1'b1, lat2);
      checks++; if (lat1 !== 3 || lat2 !== 3) begin
         failures++; $display("FAIL b2b_latency got=%0d/%0d exp=3/3", lat1, lat2); end
      checks++; if (last_wdata !== mkw(1,1,8,9,10,5) || last_waddr !== 12'h0A2) begin
         failures++; $display("FAIL b2b_second got=%h@%h exp=%h@0a2", last_wdata, last_waddr, mkw(1,1,8,9,10,5)); end
   endtask

   initial begin
      mem_rdata = mkw(1,1,2,3,4,5);
      test_reset();
      test_merge_basic();
      test_patterns();
      test_invalid();
      test_fullword();
      test_reset_in_write();
      test_busy_ignore();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
